cirno9_tcm: RTL and testbench

Parametrised tightly-coupled memory for the cirno9 CPU top, replacing the fixed 32-bit single-port SRAM. One synchronous single-port array is shared between the core's load/store port and a new AXI4 slave port used by the debug loader and DMA. The core has priority, with a starvation guard for the AXI side. The AXI side handles INCR bursts of up to 256 beats.

---
 rtl/cirno9_tcm.sv | 205 ++++++++++++++++++++
 tb/tb_cirno9_tcm.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cirno9_tcm.sv
// Tightly-coupled memory: one single-port array shared by the core load/store
// port (priority) and an AXI4 slave port for single-outstanding INCR bursts.
module cirno9_tcm #(
  parameter int          DW         = 32,
  parameter int          DEPTH      = 4096,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_tcm_val,
  input  logic [DW/8-1:0] i_tcm_wen,
  input  logic [31:0]     i_tcm_adr,
  input  logic [DW-1:0]   i_tcm_wdat,
  output logic            o_tcm_rdy,
  output logic [DW-1:0]   o_tcm_rdat,
  input  logic [31:0]     s_axi_awaddr,
  input  logic [7:0]      s_axi_awlen,
  input  logic [2:0]      s_axi_awsize,
  input  logic [1:0]      s_axi_awburst,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [DW-1:0]   s_axi_wdata,
  input  logic [DW/8-1:0] s_axi_wstrb,
  input  logic            s_axi_wlast,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  input  logic [31:0]     s_axi_araddr,
  input  logic [7:0]      s_axi_arlen,
  input  logic [2:0]      s_axi_arsize,
  input  logic [1:0]      s_axi_arburst,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [DW-1:0]   s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready
);
  localparam int BW  = DW / 8;
  localparam int OFF = $clog2(BW);
  localparam int AW  = $clog2(DEPTH);
  localparam int SW  = $clog2(STARVE_MAX + 1);
  localparam logic [33:0] WIN = 34'(DEPTH) * 34'(BW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_ISSUE,
    S_RD_DATA
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_ptr;
  logic [7:0]      r_beat;
  logic [7:0]      r_len;
  logic            r_err;
  logic            r_last_rd;
  logic [SW-1:0]   r_starve;
  logic [DW-1:0]   r_core_rdat;
  logic [DW-1:0]   r_axi_rdata;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_aw_go;
  logic            w_ar_go;
  logic            w_axi_want;
  logic            w_axi_win;
  logic            w_axi_gnt;
  logic            w_core_go;
  logic            w_last_beat;
  logic [AW-1:0]   w_core_idx;
  logic [AW-1:0]   w_aw_idx;
  logic [AW-1:0]   w_ar_idx;
  logic [AW-1:0]   w_mem_adr;
  logic            w_mem_we;
  logic [BW-1:0]   w_mem_be;
  logic [DW-1:0]   w_mem_wd;
  logic            w_unused;

  // The whole burst is rejected if its size is wrong or any beat leaves the window.
  function automatic logic f_burst_err(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size);
    logic [33:0] last_off;
    last_off = {2'b00, addr - BASE} + 34'(len) * 34'(BW);
    return (size != 3'(OFF)) || (addr < BASE) || (last_off >= WIN);
  endfunction

  assign w_unused    = ^{s_axi_awburst, s_axi_arburst, s_axi_wlast, i_tcm_adr};
  assign w_core_idx  = i_tcm_adr[OFF +: AW];
  assign w_aw_idx    = AW'((s_axi_awaddr - BASE) >> OFF);
  assign w_ar_idx    = AW'((s_axi_araddr - BASE) >> OFF);

  // On collision the side not served last wins.
  assign w_aw_go     = s_axi_awvalid && (!s_axi_arvalid || r_last_rd);
  assign w_ar_go     = s_axi_arvalid && (!s_axi_awvalid || !r_last_rd);

  assign w_axi_want  = ((r_state == S_WR_DATA) && s_axi_wvalid) || (r_state == S_RD_ISSUE);
  assign w_axi_win   = !i_tcm_val || (r_starve == SW'(STARVE_MAX));
  assign w_axi_gnt   = w_axi_want && w_axi_win;
  assign w_core_go   = i_tcm_val && !w_axi_gnt;
  assign o_tcm_rdy   = !w_axi_gnt;
  assign w_last_beat = (r_beat == r_len);

  assign s_axi_bvalid = (r_state == S_WR_RESP);
  assign s_axi_bresp  = r_err ? 2'b10 : 2'b00;
  assign s_axi_rvalid = (r_state == S_RD_DATA);
  assign s_axi_rresp  = r_err ? 2'b10 : 2'b00;
  assign s_axi_rlast  = s_axi_rvalid && w_last_beat;
  assign s_axi_rdata  = r_axi_rdata;
  assign o_tcm_rdat   = r_core_rdat;

  always_comb begin
    w_state_next  = r_state;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ar_go) begin
          s_axi_arready = 1'b1;
          w_state_next  = S_RD_ISSUE;
        end else if (w_aw_go) begin
          s_axi_awready = 1'b1;
          w_state_next  = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        s_axi_wready = w_axi_gnt;
        if (w_axi_gnt && w_last_beat) w_state_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (s_axi_bready) w_state_next = S_IDLE;
      end
      S_RD_ISSUE: begin
        if (w_axi_gnt) w_state_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (s_axi_rready) w_state_next = w_last_beat ? S_IDLE : S_RD_ISSUE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_beat    <= '0;
      r_len     <= '0;
      r_err     <= 1'b0;
      r_last_rd <= 1'b0;
      r_starve  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_starve <= (w_axi_want && !w_axi_win) ? r_starve + 1'b1 : '0;
      if (s_axi_arready) begin
        r_last_rd <= 1'b1;
        r_ptr     <= w_ar_idx;
        r_len     <= s_axi_arlen;
        r_beat    <= '0;
        r_err     <= f_burst_err(s_axi_araddr, s_axi_arlen, s_axi_arsize);
      end else if (s_axi_awready) begin
        r_last_rd <= 1'b0;
        r_ptr     <= w_aw_idx;
        r_len     <= s_axi_awlen;
        r_beat    <= '0;
        r_err     <= f_burst_err(s_axi_awaddr, s_axi_awlen, s_axi_awsize);
      end else if ((s_axi_wready || (s_axi_rvalid && s_axi_rready)) && !w_last_beat) begin
        r_beat <= r_beat + 1'b1;
        r_ptr  <= r_ptr + 1'b1;
      end
    end
  end

  assign w_mem_adr = w_axi_gnt ? r_ptr : w_core_idx;
  assign w_mem_we  = w_axi_gnt ? ((r_state == S_WR_DATA) && !r_err)
                               : (w_core_go && (i_tcm_wen != '0));
  assign w_mem_be  = w_axi_gnt ? s_axi_wstrb : i_tcm_wen;
  assign w_mem_wd  = w_axi_gnt ? s_axi_wdata : i_tcm_wdat;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < BW; b++) begin
        if (w_mem_be[b]) r_mem[w_mem_adr][b*8 +: 8] <= w_mem_wd[b*8 +: 8];
      end
    end
  end

  // Separate read registers so core data holds across AXI reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_rdat <= '0;
      r_axi_rdata <= '0;
    end else begin
      if (w_core_go && (i_tcm_wen == '0)) r_core_rdat <= r_mem[w_core_idx];
      if (w_axi_gnt && (r_state == S_RD_ISSUE)) r_axi_rdata <= r_err ? '0 : r_mem[r_ptr];
    end
  end

endmodule

// File: tb/tb_cirno9_tcm.sv
// Randomised bench for cirno9_tcm against a word-array reference model
// (DW=32, DEPTH=16 so window edges and pointer wrap are cheap to reach).
module tb_cirno9_tcm;
  localparam int          DW         = 32;
  localparam int          DEPTH      = 16;
  localparam int          BW         = 4;
  localparam int          STARVE_MAX = 8;
  localparam logic [31:0] BASE       = 32'h8000_0000;
  localparam int          TMO        = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tcm_val = 1'b0;
  logic [3:0]  i_tcm_wen = '0;
  logic [31:0] i_tcm_adr = '0;
  logic [31:0] i_tcm_wdat = '0;
  logic        o_tcm_rdy;
  logic [31:0] o_tcm_rdat;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  logic [31:0] model [DEPTH];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  cirno9_tcm #(.DW(DW), .DEPTH(DEPTH), .BASE(BASE), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_tcm_val(i_tcm_val), .i_tcm_wen(i_tcm_wen), .i_tcm_adr(i_tcm_adr),
    .i_tcm_wdat(i_tcm_wdat), .o_tcm_rdy(o_tcm_rdy), .o_tcm_rdat(o_tcm_rdat),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain per-beat address arithmetic over the window.
  function automatic bit m_err(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size);
    longint lo = longint'(BASE);
    longint hi = longint'(BASE) + longint'(DEPTH * BW);
    if (size != 3'd2) return 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      longint a = longint'(addr) + longint'(i * BW);
      if (a < lo || a >= hi) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_idx(input logic [31:0] addr, input int i);
    logic [31:0] off;
    off = addr - BASE;
    return int'(((off / 32'(BW)) + 32'(i)) % 32'(DEPTH));
  endfunction

  function automatic int c_idx(input logic [31:0] adr);
    return int'((adr / 32'(BW)) % 32'(DEPTH));
  endfunction

  task automatic m_write(input int idx, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (be[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic core_op(input logic [31:0] adr, input logic [3:0] wen, input logic [31:0] wd);
    i_tcm_val = 1'b1; i_tcm_adr = adr; i_tcm_wen = wen; i_tcm_wdat = wd;
    #1;
    check("core_rdy", o_tcm_rdy, 1'b1);
    @(posedge clk); #1;
    i_tcm_val = 1'b0; i_tcm_wen = '0;
    if (wen == 4'h0) check("core_rdat", o_tcm_rdat, model[c_idx(adr)]);
    else m_write(c_idx(adr), wen, wd);
    $display("core %s adr=%08h wen=%h data=%08h", (wen == 0) ? "rd" : "wr", adr, wen,
             (wen == 0) ? o_tcm_rdat : wd);
  endtask

  task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                       output int waits);
    waits = 0;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size; s_axi_awvalid = 1'b1;
    #1;
    while (!s_axi_awready && waits < TMO) begin @(posedge clk); #2; waits++; end
    if (!s_axi_awready) check("aw_tmo", s_axi_awready, 1'b1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                       output int waits);
    waits = 0;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size; s_axi_arvalid = 1'b1;
    #1;
    while (!s_axi_arready && waits < TMO) begin @(posedge clk); #2; waits++; end
    if (!s_axi_arready) check("ar_tmo", s_axi_arready, 1'b1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] addr, input logic [7:0] len, input bit err,
                      input bit rnd, output int cyc);
    cyc = 0;
    for (int i = 0; i <= int'(len); i++) begin
      bit done = 1'b0;
      s_axi_wdata = rnd ? $urandom : 32'(i + 1);
      s_axi_wstrb = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
      s_axi_wlast = (i == int'(len));
      while (!done && cyc < TMO) begin
        s_axi_wvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        if (s_axi_wvalid && s_axi_wready) begin
          done = 1'b1;
          if (!err) m_write(m_idx(addr, i), s_axi_wstrb, s_axi_wdata);
        end
        cyc++;
        @(posedge clk); #1;
      end
      if (!done) check("w_tmo", s_axi_wready, 1'b1);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic do_b(input bit err, input bit rnd, output int wait_c);
    bit done = 1'b0;
    wait_c = 0;
    for (int c = 0; c < TMO && !done; c++) begin
      s_axi_bready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (s_axi_bvalid) begin
        if (s_axi_bready) begin
          check("bresp", s_axi_bresp, err ? 2'b10 : 2'b00);
          done = 1'b1;
        end
      end else wait_c++;
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b0;
    if (!done) check("b_tmo", s_axi_bvalid, 1'b1);
  endtask

  task automatic do_r(input logic [31:0] addr, input logic [7:0] len, input bit err,
                      input bit rnd, input int nbeats, output int fw);
    fw = 0;
    for (int i = 0; i < nbeats; i++) begin
      bit done = 1'b0;
      int w = 0;
      while (!done && w < TMO) begin
        s_axi_rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        if (s_axi_rvalid) begin
          if (s_axi_rready) begin
            check("r_data", s_axi_rdata, err ? 32'h0 : model[m_idx(addr, i)]);
            check("r_resp", s_axi_rresp, err ? 2'b10 : 2'b00);
            check("r_last", s_axi_rlast, i == int'(len));
            done = 1'b1;
          end
        end else if (i == 0) fw++;
        w++;
        @(posedge clk); #1;
      end
      if (!done) check("r_tmo", s_axi_rvalid, 1'b1);
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input bit rnd, output int wcyc, output int bwait);
    int aw_w;
    bit err = m_err(addr, len, size);
    do_aw(addr, len, size, aw_w);
    do_w(addr, len, err, rnd, wcyc);
    do_b(err, rnd, bwait);
    $display("axi wr addr=%08h len=%0d size=%0d err=%0d cycles=%0d", addr, len, size, err, wcyc);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input bit rnd, output int arw, output int fw);
    bit err = m_err(addr, len, size);
    do_ar(addr, len, size, arw);
    do_r(addr, len, err, rnd, int'(len) + 1, fw);
    $display("axi rd addr=%08h len=%0d size=%0d err=%0d", addr, len, size, err);
  endtask

  initial begin
    int wcyc, bwait, arw, fw, lost, prev, cur, w;
    bit got, prev_ok;
    logic [31:0] sw, addr;
    logic [7:0] len;
    logic [2:0] size;

    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_wready",  s_axi_wready,  1'b0);
    check("rst_bvalid",  s_axi_bvalid,  1'b0);
    check("rst_bresp",   s_axi_bresp,   2'b00);
    check("rst_rvalid",  s_axi_rvalid,  1'b0);
    check("rst_rresp",   s_axi_rresp,   2'b00);
    check("rst_rlast",   s_axi_rlast,   1'b0);
    check("rst_rdata",   s_axi_rdata,   32'h0);
    check("rst_tcm_rdat", o_tcm_rdat,   32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) core_op(32'(i * 4), 4'hF, (i == 4) ? 32'h0 : $urandom);

    // Core-only partial write then read-back
    core_op(32'h10, 4'b0011, 32'hDEAD_BEEF);
    core_op(32'h10, 4'h0, 32'h0);
    check("core_beef", o_tcm_rdat, 32'h0000_BEEF);

    // INCR write of 1..4 with the core idle, then read back
    axi_write(BASE + 32'h20, 8'd3, 3'd2, 1'b0, wcyc, bwait);
    check("incr_wcycles", wcyc, 4);
    check("incr_bwait", bwait, 0);
    axi_read(BASE + 32'h20, 8'd3, 3'd2, 1'b0, arw, fw);
    check("incr_first_rvalid", fw, 1);
    check("incr_word3", model[11], 32'd4);
    check("core_rdat_hold", o_tcm_rdat, 32'h0000_BEEF);

    // Starvation guard: core requests every cycle while a write beat is pending
    do_aw(BASE + 32'h14, 8'd0, 3'd2, arw);
    sw = $urandom;
    s_axi_wdata = sw; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    i_tcm_val = 1'b1; i_tcm_wen = 4'h0;
    lost = 0; got = 1'b0; prev_ok = 1'b0; prev = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      cur = $urandom_range(0, DEPTH - 1);
      i_tcm_adr = 32'(cur * 4);
      #1;
      if (prev_ok) check("starve_core_rdat", o_tcm_rdat, model[prev]);
      if (s_axi_wready) begin
        got = 1'b1;
        check("starve_win_rdy", o_tcm_rdy, 1'b0);
      end else begin
        lost++;
        check("starve_lose_rdy", o_tcm_rdy, 1'b1);
        prev_ok = 1'b1; prev = cur;
      end
      @(posedge clk); #1;
    end
    i_tcm_val = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("starve_lost", lost, STARVE_MAX);
    if (got) m_write(5, 4'hF, sw);
    do_b(1'b0, 1'b0, bwait);
    $display("starve lost=%0d granted=%0d", lost, got);
    core_op(32'h14, 4'h0, 32'h0);

    // Error bursts: below the window, across the top, wrong size, long drain
    axi_write(BASE - 32'h4, 8'd1, 3'd2, 1'b0, wcyc, bwait);
    check("err_wcycles", wcyc, 2);
    core_op(32'h3C, 4'h0, 32'h0);
    core_op(32'h00, 4'h0, 32'h0);
    axi_read(BASE, 8'd2, 3'd1, 1'b0, arw, fw);
    axi_write(BASE + 32'h3C, 8'd1, 3'd2, 1'b0, wcyc, bwait);
    core_op(32'h3C, 4'h0, 32'h0);
    axi_read(BASE, 8'd40, 3'd2, 1'b0, arw, fw);

    // Last word of the window, and core address wrap onto word 0
    axi_write(BASE + 32'h3C, 8'd0, 3'd2, 1'b0, wcyc, bwait);
    core_op(32'h7C, 4'h0, 32'h0);
    check("wrap_last_word", o_tcm_rdat, 32'd1);
    core_op(32'h40, 4'hF, 32'hA5A5_0F0F);
    axi_read(BASE, 8'd0, 3'd2, 1'b0, arw, fw);

    // Reset during beat 2 of a 4-beat read
    do_ar(BASE, 8'd3, 3'd2, arw);
    do_r(BASE, 8'd3, 1'b0, 1'b0, 1, fw);
    s_axi_rready = 1'b0; w = 0;
    #1;
    while (!s_axi_rvalid && w < TMO) begin @(posedge clk); #2; w++; end
    check("rst_mid_pre_rvalid", s_axi_rvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_rvalid", s_axi_rvalid, 1'b0);
    check("rst_mid_tcm_rdat", o_tcm_rdat, 32'h0);
    $display("reset mid-burst applied");

    // AW/AR collisions: read first after reset, and again after a write
    for (int k = 0; k < 2; k++) begin
      s_axi_awaddr = BASE + 32'h8; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
      s_axi_araddr = BASE + 32'h20; s_axi_arlen = 8'd1; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
      #1;
      check("col_arready", s_axi_arready, 1'b1);
      check("col_awready", s_axi_awready, 1'b0);
      axi_read(BASE + 32'h20, 8'd1, 3'd2, 1'b0, arw, fw);
      check("col_ar_wait", arw, 0);
      axi_write(BASE + 32'h8, 8'd0, 3'd2, 1'b0, wcyc, bwait);
      $display("collision %0d served read then write", k);
    end

    // Randomised mix of core and AXI traffic
    for (int t = 0; t < 80; t++) begin
      int op = $urandom_range(0, 3);
      int sel = $urandom_range(0, 9);
      if (sel == 0) addr = BASE - 32'($urandom_range(1, 3)) * 32'd4;
      else addr = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      len = 8'($urandom_range(0, (sel == 1) ? 20 : 5));
      size = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      case (op)
        0: core_op($urandom, 4'($urandom_range(0, 15)), $urandom);
        1: core_op($urandom, 4'h0, 32'h0);
        2: axi_write(addr, len, size, 1'b1, wcyc, bwait);
        default: axi_read(addr, len, size, 1'b1, arw, fw);
      endcase
    end
    for (int i = 0; i < DEPTH; i++) core_op(32'(i * 4), 4'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
